data_sink: RTL and testbench
============================

DATA_SINK -- requirements
Module: data_sink

Interface
REQ-001 clk  input  1  system clock; all state changes on its rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 ena_in  input  1  write strobe from the upstream address/data source; level-sampled each clk edge.
REQ-004 addr_in  input  4  write address, 0..15.
REQ-005 data_in  input  4  write data.
REQ-006 dump_req  input  1  request to stream out the whole store; sampled each clk edge.
REQ-007 dout  output  4  dump beat data, registered.
REQ-008 dout_addr  output  4  address of the current dump beat, registered.
REQ-009 dout_valid  output  1  high on each dump beat.
REQ-010 busy  output  1  high while in DUMP.
REQ-011 filled  output  1  high when all 16 addresses have been written since the last clear.
REQ-012 wr_count  output  5  number of distinct addresses written since the last clear, 0..16.
REQ-013 dropped  output  1  sticky; set when a write is refused during DUMP.

Function
REQ-014 The block SHALL hold a 16x4 store plus a 16-bit written mask.
REQ-015 FSM states SHALL be IDLE and DUMP only; reset state is IDLE.
REQ-016 In IDLE, on an edge with ena_in=1, the block SHALL write data_in to store[addr_in] and set mask[addr_in].
REQ-017 A rewrite of an already-marked address SHALL overwrite the data and leave wr_count unchanged.
REQ-018 wr_count SHALL equal the popcount of the mask and be updated at the same edge as the mask; filled SHALL equal (wr_count==16).
REQ-019 IDLE->DUMP SHALL occur at the edge where dump_req=1; at that edge dropped SHALL clear.
REQ-020 If ena_in and dump_req are both high in IDLE, the write SHALL be accepted and beat 0 SHALL reflect it; a write to address 0 in that cycle SHALL appear on dout at beat 0.
REQ-021 Beat k (k=0..15) SHALL be visible after edge N+k, where N is the entry edge: dout_valid=1, dout_addr=k, dout=store[k] (value 0 if never written since reset).
REQ-022 At edge N+16 the block SHALL return to IDLE with dout_valid=0, busy=0, mask cleared, wr_count=0 and filled=0; store contents SHALL be retained.
REQ-023 In DUMP, ena_in=1 SHALL NOT modify store or mask, and SHALL set dropped.
REQ-024 In DUMP, dump_req SHALL be ignored; no restart or extension occurs.
REQ-025 busy SHALL be high exactly for the 16 beat cycles.
REQ-026 dout and dout_addr SHALL hold their last values when dout_valid=0.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, store all 0, mask 0, and outputs dout=0, dout_addr=0, dout_valid=0, busy=0, filled=0, wr_count=0, dropped=0.
REQ-028 Reset asserted mid-DUMP SHALL abort the dump; no further beats appear after release.
REQ-029 The first write SHALL be accepted on the first clk edge after rst deasserts.

Configuration
REQ-030 Macro DATA_SINK_CHECKSUM_EN, when defined, SHALL add output checksum[7:0]: the modulo-256 sum of data_in over all accepted writes. It is cleared by reset and at the DUMP->IDLE edge, and refused writes are excluded.
REQ-031 Without DATA_SINK_CHECKSUM_EN, the checksum port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-032 Reset, then write addr 0..15 with data=addr in 16 consecutive cycles -> wr_count steps 1..16, filled=1 after the 16th edge, checksum=120.
REQ-033 Write addr 3 data 5, then addr 3 data 9 -> wr_count=1, and a subsequent dump shows beat 3 dout=9 and all other beats dout=0.
REQ-034 Pulse dump_req at edge N -> dout_valid high after edges N..N+15 with dout_addr 0..15, low after N+16, wr_count=0.
REQ-035 Assert ena_in (addr 7, data F) during beat 4 -> store unchanged, dropped=1; the next dump_req clears dropped.
REQ-036 Same cycle in IDLE: ena_in with addr 0, data A and dump_req -> beat 0 dout=A.
REQ-037 Assert rst at beat 8 -> all outputs 0 immediately, and no beats appear after release.

Source files
------------

// File: rtl/data_sink.sv
// data_sink: 16x4 write store with a written mask, streamed out on request as 16 beats.
// Optional checksum output enabled by defining DATA_SINK_CHECKSUM_EN.
module data_sink (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena_in,
  input  logic [3:0] addr_in,
  input  logic [3:0] data_in,
  input  logic       dump_req,
  output logic [3:0] dout,
  output logic [3:0] dout_addr,
  output logic       dout_valid,
  output logic       busy,
  output logic       filled,
  output logic [4:0] wr_count,
  output logic       dropped
`ifdef DATA_SINK_CHECKSUM_EN
  ,
  output logic [7:0] checksum
`endif
);

  localparam logic IDLE = 1'b0;
  localparam logic DUMP = 1'b1;

  logic        state_q,     state_d;
  logic [3:0]  store_q [16];
  logic [3:0]  store_d [16];
  logic [15:0] mask_q,      mask_d;
  logic [4:0]  wr_count_q,  wr_count_d;
  logic [3:0]  dout_q,      dout_d;
  logic [3:0]  dout_addr_q, dout_addr_d;
  logic        dropped_q,   dropped_d;
  logic        wr_acc;
`ifdef DATA_SINK_CHECKSUM_EN
  logic [7:0]  checksum_q,  checksum_d;
`endif

  assign wr_acc = (state_q == IDLE) && ena_in;

  always_comb begin
    state_d     = state_q;
    store_d     = store_q;
    mask_d      = mask_q;
    wr_count_d  = wr_count_q;
    dout_d      = dout_q;
    dout_addr_d = dout_addr_q;
    dropped_d   = dropped_q;
`ifdef DATA_SINK_CHECKSUM_EN
    checksum_d  = checksum_q;
`endif

    if (wr_acc) begin
      store_d[addr_in] = data_in;
      mask_d[addr_in]  = 1'b1;
      if (!mask_q[addr_in]) begin
        wr_count_d = wr_count_q + 5'd1;
      end
`ifdef DATA_SINK_CHECKSUM_EN
      checksum_d = checksum_q + {4'b0000, data_in};
`endif
    end

    case (state_q)
      IDLE: begin
        if (dump_req) begin
          state_d     = DUMP;
          dropped_d   = 1'b0;
          dout_addr_d = '0;
          // beat 0 reads the post-write store so a same-cycle write to addr 0 is visible
          dout_d      = store_d[0];
        end
      end
      default: begin
        if (ena_in) begin
          dropped_d = 1'b1;
        end
        // dout_addr_q doubles as the beat index while dumping
        if (dout_addr_q == 4'd15) begin
          state_d    = IDLE;
          mask_d     = '0;
          wr_count_d = '0;
`ifdef DATA_SINK_CHECKSUM_EN
          checksum_d = '0;
`endif
        end else begin
          dout_addr_d = dout_addr_q + 4'd1;
          dout_d      = store_q[dout_addr_q + 4'd1];
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      store_q     <= '{default: '0};
      mask_q      <= '0;
      wr_count_q  <= '0;
      dout_q      <= '0;
      dout_addr_q <= '0;
      dropped_q   <= 1'b0;
`ifdef DATA_SINK_CHECKSUM_EN
      checksum_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      store_q     <= store_d;
      mask_q      <= mask_d;
      wr_count_q  <= wr_count_d;
      dout_q      <= dout_d;
      dout_addr_q <= dout_addr_d;
      dropped_q   <= dropped_d;
`ifdef DATA_SINK_CHECKSUM_EN
      checksum_q  <= checksum_d;
`endif
    end
  end

  assign dout       = dout_q;
  assign dout_addr  = dout_addr_q;
  assign dout_valid = (state_q == DUMP);
  assign busy       = (state_q == DUMP);
  assign wr_count   = wr_count_q;
  assign filled     = (wr_count_q == 5'd16);
  assign dropped    = dropped_q;
`ifdef DATA_SINK_CHECKSUM_EN
  assign checksum   = checksum_q;
`endif

endmodule

// File: tb/tb_data_sink.sv
// Bench for data_sink: vector table, directed corner sequences, and random traffic
// checked against a store/queue reference model.
module tb_data_sink;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena_in;
  logic [3:0] addr_in;
  logic [3:0] data_in;
  logic       dump_req;
  logic [3:0] dout;
  logic [3:0] dout_addr;
  logic       dout_valid;
  logic       busy;
  logic       filled;
  logic [4:0] wr_count;
  logic       dropped;
`ifdef DATA_SINK_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  data_sink dut (
    .clk        (clk),
    .rst        (rst),
    .ena_in     (ena_in),
    .addr_in    (addr_in),
    .data_in    (data_in),
    .dump_req   (dump_req),
    .dout       (dout),
    .dout_addr  (dout_addr),
    .dout_valid (dout_valid),
    .busy       (busy),
    .filled     (filled),
    .wr_count   (wr_count),
    .dropped    (dropped)
`ifdef DATA_SINK_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: store snapshot queued as beats on dump entry
  logic [3:0] m_store [16];
  bit         m_mask  [16];
  logic [7:0] m_q[$];
  bit         m_dump;
  logic [3:0] e_dout, e_addr;
  bit         e_valid, e_dropped;
  logic [7:0] m_sum;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_store[i] = '0;
      m_mask[i]  = 0;
    end
    m_q.delete();
    m_dump = 0; e_dout = '0; e_addr = '0; e_valid = 0; e_dropped = 0; m_sum = '0;
  endtask

  task automatic model_show();
    logic [7:0] b;
    b = m_q.pop_front();
    e_valid = 1;
    e_addr  = b[7:4];
    e_dout  = b[3:0];
  endtask

  task automatic model_step(input logic ena, input logic [3:0] a, input logic [3:0] d,
                            input logic dmp);
    if (!m_dump) begin
      if (ena) begin
        m_store[a] = d;
        m_mask[a]  = 1;
        m_sum      = m_sum + 8'(d);
      end
      if (dmp) begin
        m_dump    = 1;
        e_dropped = 0;
        for (int k = 0; k < 16; k++) m_q.push_back({4'(k), m_store[k]});
        model_show();
      end
    end else begin
      if (ena) e_dropped = 1;
      if (m_q.size() > 0) model_show();
      else begin
        m_dump  = 0;
        e_valid = 0;
        m_sum   = '0;
        for (int i = 0; i < 16; i++) m_mask[i] = 0;
      end
    end
  endtask

  function automatic logic [4:0] m_count();
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(m_mask[i]);
    return 5'(n);
  endfunction

  function automatic logic [16:0] exp_vec();
    logic [4:0] c = m_count();
    return {e_dout, e_addr, e_valid, e_valid, (c == 5'd16), c, e_dropped};
  endfunction

  function automatic logic [16:0] dut_vec();
    return {dout, dout_addr, dout_valid, busy, filled, wr_count, dropped};
  endfunction

  task automatic set_in(input logic e, input logic [3:0] a, input logic [3:0] d, input logic r);
    ena_in = e; addr_in = a; data_in = d; dump_req = r;
  endtask

  task automatic tick(input string name);
    @(posedge clk);
    model_step(ena_in, addr_in, data_in, dump_req);
    #1;
    check(name, 32'(dut_vec()), 32'(exp_vec()));
`ifdef DATA_SINK_CHECKSUM_EN
    check({name, "_csum"}, 32'(checksum), 32'(m_sum));
`endif
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1;
    #1;
    model_reset();
    check(name, 32'(dut_vec()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic       ena;
    logic [3:0] addr;
    logic [3:0] data;
    logic       dmp;
    logic [4:0] wc;
    logic       fl;
    logic       vld;
    logic [3:0] da;
    logic [3:0] dd;
  } vec_t;

  function automatic vec_t mk(input logic e, input logic [3:0] a, input logic [3:0] d,
                              input logic r, input logic [4:0] wc, input logic fl,
                              input logic vld, input logic [3:0] da, input logic [3:0] dd);
    vec_t v;
    v.ena = e; v.addr = a; v.data = d; v.dmp = r;
    v.wc = wc; v.fl = fl; v.vld = vld; v.da = da; v.dd = dd;
    return v;
  endfunction

  vec_t vt[$];

  initial begin
    // 16 writes addr=data, then a full dump of that content and the return to idle
    for (int i = 0; i < 16; i++)
      vt.push_back(mk(1'b1, 4'(i), 4'(i), 1'b0, 5'(i + 1), (i == 15), 1'b0, 4'd0, 4'd0));
    vt.push_back(mk(1'b0, 4'd0, 4'd0, 1'b1, 5'd16, 1'b1, 1'b1, 4'd0, 4'd0));
    for (int k = 1; k < 16; k++)
      vt.push_back(mk(1'b0, 4'd0, 4'd0, 1'b0, 5'd16, 1'b1, 1'b1, 4'(k), 4'(k)));
    vt.push_back(mk(1'b0, 4'd0, 4'd0, 1'b0, 5'd0, 1'b0, 1'b0, 4'd15, 4'd15));

    set_in(1'b0, 4'd0, 4'd0, 1'b0);
    do_reset("reset_initial");

    foreach (vt[i]) begin
      set_in(vt[i].ena, vt[i].addr, vt[i].data, vt[i].dmp);
      tick("vec_model");
      check($sformatf("vec[%0d]", i),
            32'({wr_count, filled, dout_valid, dout_addr, dout}),
            32'({vt[i].wc, vt[i].fl, vt[i].vld, vt[i].da, vt[i].dd}));
`ifdef DATA_SINK_CHECKSUM_EN
      if (i == 15) check("csum_120", 32'(checksum), 32'd120);
`endif
    end
    set_in(1'b0, 4'd0, 4'd0, 1'b0);
    tick("idle");

    // rewrite of the same address
    do_reset("reset_rewrite");
    set_in(1'b1, 4'd3, 4'd5, 1'b0); tick("rw1");
    set_in(1'b1, 4'd3, 4'd9, 1'b0); tick("rw2");
    check("rewrite_count", 32'(wr_count), 32'd1);
    set_in(1'b0, 4'd0, 4'd0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      tick("rw_dump");
      set_in(1'b0, 4'd0, 4'd0, 1'b0);
      check($sformatf("rewrite_beat%0d", k), 32'({dout_addr, dout}),
            32'({4'(k), (k == 3) ? 4'd9 : 4'd0}));
    end
    tick("rw_exit");
    check("exit_valid", 32'({dout_valid, busy, wr_count}), 32'd0);

    // write refused during dump
    set_in(1'b0, 4'd0, 4'd0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick("drop_dump");
      set_in(1'b0, 4'd0, 4'd0, 1'b0);
    end
    set_in(1'b1, 4'd7, 4'hF, 1'b0); tick("drop_wr");
    check("dropped_set", 32'(dropped), 32'd1);
    set_in(1'b0, 4'd0, 4'd0, 1'b1); tick("drop_ignored_req");
    set_in(1'b0, 4'd0, 4'd0, 1'b0);
    for (int k = 0; k < 11; k++) tick("drop_rest");
    check("dump_ended", 32'(busy), 32'd0);
    check("dropped_sticky", 32'(dropped), 32'd1);
    set_in(1'b0, 4'd0, 4'd0, 1'b1); tick("redump");
    set_in(1'b0, 4'd0, 4'd0, 1'b0);
    check("dropped_clear", 32'(dropped), 32'd0);
    for (int k = 1; k < 16; k++) begin
      tick("redump_beats");
      if (k == 7) check("store_unchanged7", 32'(dout), 32'd0);
    end
    tick("redump_exit");

    // same-cycle write to addr 0 and dump request
    set_in(1'b1, 4'd0, 4'hA, 1'b1); tick("same_cycle");
    set_in(1'b0, 4'd0, 4'd0, 1'b0);
    check("same_cycle_beat0", 32'({dout_valid, dout_addr, dout}), 32'({1'b1, 4'd0, 4'hA}));
    for (int k = 0; k < 16; k++) tick("same_rest");

    // reset mid-dump
    set_in(1'b0, 4'd0, 4'd0, 1'b1);
    for (int k = 0; k < 9; k++) begin
      tick("abort_dump");
      set_in(1'b0, 4'd0, 4'd0, 1'b0);
    end
    check("abort_at_beat8", 32'(dout_addr), 32'd8);
    do_reset("reset_mid_dump");
    for (int k = 0; k < 20; k++) tick("after_abort");
    check("no_beats_after_abort", 32'(dout_valid), 32'd0);

    // random traffic
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 199) == 0) do_reset("reset_rand");
      set_in(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom),
             ($urandom_range(0, 11) == 0));
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
